// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and helpers for the register file slice
package regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NUM_RD = 2;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);
  typedef logic [DEF_NUM_RD-1:0][DEF_ADDR_W-1:0] rd_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with set/clear/flush and read-port lookups
module rf_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           set_en,
  input  logic [ADDR_W-1:0]              set_addr,
  input  logic                           clr_en,
  input  logic [ADDR_W-1:0]              clr_addr,
  input  logic                           flush,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              rd_pending
);
  logic [DEPTH-1:0] pending, nxt;
  // flush beats set, and set beats clear because the issuing instruction is the newer producer
  always_comb begin
    nxt = pending;
    for (int i = 0; i < DEPTH; i++)
      nxt[i] = flush ? 1'b0 :
               (set_en && set_addr == ADDR_W'(i)) ? 1'b1 :
               (clr_en && clr_addr == ADDR_W'(i)) ? 1'b0 : pending[i];
  end
  // pending vector state
  always_ff @(posedge clk or negedge rst)
    if (!rst) pending <= '0;
    else pending <= nxt;
  // register 0 is never reported pending
  always_comb begin
    rd_pending = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_pending[p] = (rd_addr[p] != '0) && pending[rd_addr[p]];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with bypass, pending-write scoreboard and sequential bulk clear
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_pending,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_addr,
  input  logic                           clear_req,
  output logic                           ready,
  output logic                           clear_done
);
  rf_state_e state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic idle, accept, we, set_en, byp_ok;
  assign idle = state == RF_IDLE;
  assign ready = idle;
  // a clear request in IDLE swallows that cycle's write and issue
  assign accept = idle && !clear_req;
  assign we = accept && wr_en && wr_addr != '0;
  assign set_en = accept && issue_en && issue_addr != '0;
  assign byp_ok = (BYPASS != 0) && idle && wr_en;
  // clear FSM: walks cnt over every register, pulses clear_done on return to IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RF_IDLE;
      cnt <= '0;
      clear_done <= 1'b0;
    end else if (idle) begin
      clear_done <= 1'b0;
      cnt <= '0;
      state <= clear_req ? RF_CLEAR : RF_IDLE;
    end else begin
      cnt <= cnt + 1'b1;
      state <= (cnt == ADDR_W'(DEPTH - 1)) ? RF_IDLE : RF_CLEAR;
      clear_done <= cnt == ADDR_W'(DEPTH - 1);
    end
  // storage: the clear engine owns the write port while running
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '0;
    else if (!idle) mem[cnt] <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  // combinational reads with optional same-cycle forwarding of the write data
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_data[p] = (rd_addr[p] == '0) ? '0 :
                   (byp_ok && wr_addr == rd_addr[p]) ? wr_data : mem[rd_addr[p]];
  end
  rf_scoreboard #(.DEPTH(DEPTH), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(set_en),
    .set_addr(issue_addr),
    .clr_en(we),
    .clr_addr(wr_addr),
    .flush(idle && clear_req),
    .rd_addr(rd_addr),
    .rd_pending(rd_pending)
  );
endmodule
